// File: rtl/fp32_to_q16_conv.sv
// IEEE-754 single to signed Q16.16 converter using a one-bit-per-cycle shifter.
// Optional macro CONV_ROUND_EN: round half away from zero on right shifts instead of truncating.
module fp32_to_q16_conv #(
  parameter int unsigned MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R_I,
  input  logic [31:0] dataIn,
  input  logic [1:0]  errIn,
  output logic [31:0] dataOut,
  output logic        r_o,
  output logic [1:0]  err,
  output logic        busy
);

  localparam int unsigned CntW   = (MAX_SHIFT > 7) ? $clog2(MAX_SHIFT + 1) : 3;
  localparam int          MinExp = 134 - int'(MAX_SHIFT);

  typedef enum logic [1:0] {StIdle, StCheck, StShift, StOut} state_e;

  state_e          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      errin_q, errin_d;
  logic [31:0]     work_q, work_d;
  logic            left_q, left_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     dout_q, dout_d;
  logic [1:0]      err_q, err_d;
  logic [7:0]      exp_w;
  logic [7:0]      diff_w;
`ifdef CONV_ROUND_EN
  logic            round_q, round_d;
  logic [32:0]     mag_w;
`endif

  assign exp_w = word_q[30:23];

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    errin_d = errin_q;
    work_d  = work_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    err_d   = err_q;
    diff_w  = 8'd0;
`ifdef CONV_ROUND_EN
    round_d = round_q;
    mag_w   = {1'b0, work_q} + {32'd0, round_q};
`endif
    unique case (state_q)
      StIdle: begin
        if (R_I) begin
          word_d  = dataIn;
          errin_d = errIn;
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StOut;
        if (errin_q != 2'b00) begin
          dout_d = 32'd0;
          err_d  = 2'b11;
        end else if (exp_w == 8'd255) begin
          dout_d = 32'd0;
          err_d  = 2'b10;
        end else if (exp_w == 8'd0 || int'(exp_w) < MinExp) begin
          dout_d = 32'd0;
          err_d  = 2'b00;
        end else if (exp_w >= 8'd142) begin
          dout_d = word_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          err_d  = 2'b01;
        end else begin
          work_d  = {8'd0, 1'b1, word_q[22:0]};
          left_d  = exp_w > 8'd134;
          diff_w  = (exp_w > 8'd134) ? (exp_w - 8'd134) : (8'd134 - exp_w);
          cnt_d   = CntW'(diff_w);
          state_d = StShift;
`ifdef CONV_ROUND_EN
          round_d = 1'b0;
`endif
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          work_d = left_q ? {work_q[30:0], 1'b0} : {1'b0, work_q[31:1]};
          cnt_d  = cnt_q - 1'b1;
`ifdef CONV_ROUND_EN
          // Remember the last bit dropped off the bottom as the round bit.
          if (!left_q) round_d = work_q[0];
`endif
        end else begin
          state_d = StOut;
          err_d   = 2'b00;
`ifdef CONV_ROUND_EN
          if (mag_w[32] || mag_w[31]) begin
            dout_d = word_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            err_d  = 2'b01;
          end else begin
            dout_d = word_q[31] ? (~mag_w[31:0] + 32'd1) : mag_w[31:0];
          end
`else
          dout_d = word_q[31] ? (~work_q + 32'd1) : work_q;
`endif
        end
      end
      StOut: begin
        // Back-to-back: a word presented on the edge leaving OUT is taken.
        if (R_I) begin
          word_d  = dataIn;
          errin_d = errIn;
          state_d = StCheck;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      word_q  <= 32'd0;
      errin_q <= 2'b00;
      work_q  <= 32'd0;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 32'd0;
      err_q   <= 2'b00;
`ifdef CONV_ROUND_EN
      round_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      errin_q <= errin_d;
      work_q  <= work_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
`ifdef CONV_ROUND_EN
      round_q <= round_d;
`endif
    end
  end

  assign dataOut = dout_q;
  assign err     = err_q;
  assign r_o     = (state_q == StOut);
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_fp32_to_q16_conv.sv
// Bench for fp32_to_q16_conv: vector table plus hand sequences, checked through a result queue.
module tb_fp32_to_q16_conv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        R_I = 1'b0;
  logic [31:0] dataIn = 32'd0;
  logic [1:0]  errIn = 2'b00;
  logic [31:0] dataOut;
  logic        r_o;
  logic [1:0]  err;
  logic        busy;

  fp32_to_q16_conv dut (
    .clk    (clk),
    .reset  (reset),
    .R_I    (R_I),
    .dataIn (dataIn),
    .errIn  (errIn),
    .dataOut(dataOut),
    .r_o    (r_o),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [1:0]  ein;
    logic [31:0] dout;
    logic [1:0]  eout;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic [1:0]  eout;
    int          lat;
    int          t;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (r_o) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_r_o: got r_o=1 expected no pulse (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("dataOut[%0d]", e.id), dataOut, e.dout);
        chk($sformatf("err[%0d]", e.id), {30'd0, err}, {30'd0, e.eout});
        chk($sformatf("latency[%0d]", e.id), cyc - e.t, e.lat);
        chk($sformatf("busy_at_r_o[%0d]", e.id), {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] e, input logic [31:0] dout,
                      input logic [1:0] eout, input int lat, input bit push, input int id);
    exp_t x;
    wait_idle();
    R_I    = 1'b1;
    dataIn = d;
    errIn  = e;
    @(posedge clk);
    #1;
    R_I = 1'b0;
    x.dout = dout; x.eout = eout; x.lat = lat; x.t = cyc; x.id = id;
    if (push) sb.push_back(x);
    chk($sformatf("busy_after_accept[%0d]", id), {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  vec_t vecs[15];

  initial begin
    int p0;
    exp_t x;
    int n;

    vecs[0]  = '{32'h40A0_0000, 2'b00, 32'h0005_0000, 2'b00, 7};   // 5.0
    vecs[1]  = '{32'hC020_0000, 2'b00, 32'hFFFD_8000, 2'b00, 8};   // -2.5
    vecs[2]  = '{32'h4780_0000, 2'b00, 32'h7FFF_FFFF, 2'b01, 1};   // 65536.0
    vecs[3]  = '{32'hC700_0000, 2'b00, 32'h8000_0000, 2'b01, 1};   // -32768.0
    vecs[4]  = '{32'h7FC0_0000, 2'b00, 32'h0000_0000, 2'b10, 1};   // NaN
    vecs[5]  = '{32'h40A0_0000, 2'b10, 32'h0000_0000, 2'b11, 1};   // upstream error
`ifdef CONV_ROUND_EN
    vecs[6]  = '{32'h3700_0000, 2'b00, 32'h0000_0001, 2'b00, 26};  // 2^-17
    vecs[7]  = '{32'h3F80_0040, 2'b00, 32'h0001_0001, 2'b00, 9};
`else
    vecs[6]  = '{32'h3700_0000, 2'b00, 32'h0000_0000, 2'b00, 26};
    vecs[7]  = '{32'h3F80_0040, 2'b00, 32'h0001_0000, 2'b00, 9};
`endif
    vecs[8]  = '{32'h3F80_0000, 2'b00, 32'h0001_0000, 2'b00, 9};   // 1.0
    vecs[9]  = '{32'h0000_0000, 2'b00, 32'h0000_0000, 2'b00, 1};   // zero
    vecs[10] = '{32'h3680_0000, 2'b00, 32'h0000_0000, 2'b00, 1};   // 2^-18, below range
    vecs[11] = '{32'h46FF_FE00, 2'b00, 32'h7FFF_0000, 2'b00, 9};   // 32767.0, 7 left
    vecs[12] = '{32'hBF40_0000, 2'b00, 32'hFFFF_4000, 2'b00, 10};  // -0.75
    vecs[13] = '{32'h7F80_0000, 2'b00, 32'h0000_0000, 2'b10, 1};   // +Inf
    vecs[14] = '{32'h3FC0_0000, 2'b00, 32'h0001_8000, 2'b00, 9};   // 1.5

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_dataOut", dataOut, 32'd0);
    chk("reset_err", {30'd0, err}, 32'd0);
    chk("reset_r_o", {31'd0, r_o}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      send(vecs[i].din, vecs[i].ein, vecs[i].dout, vecs[i].eout, vecs[i].lat, 1'b1, i);
      drain();
    end

    // Back-to-back: next word held on R_I from the edge that leaves OUT.
    send(32'hC020_0000, 2'b00, 32'hFFFD_8000, 2'b00, 8, 1'b1, 100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r_o && n < 50);
    chk("b2b_saw_r_o", {31'd0, r_o}, 32'd1);
    R_I    = 1'b1;
    dataIn = 32'h40E0_0000;
    errIn  = 2'b00;
    @(posedge clk);
    #1;
    R_I = 1'b0;
    x.dout = 32'h0007_0000; x.eout = 2'b00; x.lat = 7; x.t = cyc; x.id = 101;
    sb.push_back(x);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    drain();

    // R_I pulses while busy must be ignored.
    p0 = pulses;
    send(32'h40A0_0000, 2'b00, 32'h0005_0000, 2'b00, 7, 1'b1, 102);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      R_I    = 1'b1;
      dataIn = 32'h3F80_0000;
      @(negedge clk);
      R_I = 1'b0;
    end
    drain();
    repeat (5) @(negedge clk);
    chk("busy_ignore_pulses", pulses - p0, 32'd1);

    // Reset in the middle of SHIFT aborts with no pulse.
    p0 = pulses;
    send(32'h40A0_0000, 2'b00, 32'd0, 2'b00, 0, 1'b0, 103);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midreset_dataOut", dataOut, 32'd0);
    chk("midreset_err", {30'd0, err}, 32'd0);
    chk("midreset_r_o", {31'd0, r_o}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("midreset_no_pulse", pulses - p0, 32'd0);

    send(32'h40A0_0000, 2'b00, 32'h0005_0000, 2'b00, 7, 1'b1, 104);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_to_q16_conv.md
Name: fp32_to_q16_conv

Overview:
- Downstream of the 16-to-32-bit word assembler FSM.
- Consumes each assembled IEEE-754 single-precision word together with its ready strobe and error code.
- Converts the word to signed Q16.16 fixed point with an iterative one-bit-per-cycle shifter.
- Emits the result with a one-cycle ready pulse and its own error code.

Parameters:
- MAX_SHIFT, 24, largest right-shift count handled iteratively; exponents below 134-MAX_SHIFT yield 0 directly.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- R_I  input  1  upstream ready strobe; dataIn/errIn valid when high.
- dataIn  input  32  fp32 word: [31] sign, [30:23] exponent, [22:0] fraction.
- errIn  input  2  upstream error code; nonzero means the word is invalid.
- dataOut  output  32  signed Q16.16 result, two's complement.
- r_o  output  1  result-ready pulse, exactly one cycle.
- err  output  2  00 ok, 01 overflow (saturated), 10 NaN/Inf, 11 upstream error.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0 at a rising edge): state IDLE, dataOut=0, r_o=0, err=00, busy=0. Applies from any state and aborts a conversion in progress. No output pulse for the aborted word.
- States: IDLE, CHECK, SHIFT, OUT.
- IDLE, edge T with R_I=1: latch dataIn and errIn, go to CHECK.
  - R_I is ignored in every other state; the word is dropped with no error.
  - busy=1 from after edge T until OUT is left.
- CHECK, edge T+1, let e = exponent, m = {1, fraction} (24 bits):
  - errIn!=0: dataOut=0, err=11, go to OUT.
  - e==255: dataOut=0, err=10, go to OUT.
  - e==0 (zero or denormal) or e<=133-MAX_SHIFT (default e<=109): dataOut=0, err=00, go to OUT.
  - e>=142 (|value| >= 32768): saturate, err=01, go to OUT. Positive gives 0x7FFFFFFF; negative gives 0x80000000, including exactly -32768.0.
  - Otherwise: load working register with m, direction = left if e>134, count n=|e-134|, go to SHIFT.
- SHIFT: at each edge with count!=0, shift working register one bit in the chosen direction (logical, zero fill) and decrement count.
  - At the edge where count==0, go to OUT with dataOut = sign ? -work : work, err=00.
  - Result truncates the magnitude toward zero.
  - Left shifts are never more than 7; right shifts are never more than 24.
- OUT: r_o=1 for this one cycle, with dataOut/err valid. Next edge goes to IDLE and r_o=0.
  - dataOut and err hold their values until the next OUT entry or reset.
- Latency:
  - Special cases: r_o high in the cycle after edge T+1.
  - Normal words: r_o high in the cycle after edge T+2+n.
- Back-to-back: the earliest next acceptance is the edge that leaves OUT; R_I sampled at that edge is accepted.

Optional Feature:
- Macro CONV_ROUND_EN.
- Defined: keep the last bit shifted out during right shifts as the round bit. After SHIFT, magnitude = work + round bit (round half away from zero), then negate if sign. A rounding carry that reaches 2^31 saturates with err=01. Left shifts and special cases are unchanged.
- Undefined: pure truncation as above; no round-bit register is synthesised.

Test Plan:
- 0x40A00000 (5.0), errIn=00, R_I pulse at edge T -> n=5, r_o one cycle after edge T+7, dataOut=0x00050000, err=00, busy falls with r_o.
- 0xC0200000 (-2.5) -> dataOut=0xFFFD8000, err=00. Then 0x40E00000 (7.0) with R_I held high from the OUT-leaving edge -> dataOut=0x00070000.
- 0x47800000 (65536.0) -> dataOut=0x7FFFFFFF, err=01. 0xC7000000 (-32768.0) -> 0x80000000, err=01. 0x7FC00000 (NaN) -> 0x00000000, err=10. All with r_o in the cycle after edge T+1.
- Word 0x40A00000 with errIn=10 -> dataOut=0, err=11. R_I pulses while busy=1 -> ignored, exactly one r_o per accepted word.
- 0x37000000 (2^-17, n=24) -> 0x00000000 without CONV_ROUND_EN, 0x00000001 with it. 0x3F800000 (1.0) -> 0x00010000 in both builds.
- Assert reset=0 mid-SHIFT on a 5.0 conversion -> next edge: IDLE, dataOut=0, r_o=0, err=00, busy=0, no pulse. A new word afterwards converts normally.
